// File: rtl/keypad_debounce_encoder_pkg.sv
// Shared constants, encoder state type and bit-vector helpers for the keypad
// conditioning block feeding the mole-game main FSM.
package keypad_debounce_encoder_pkg;

    localparam int NUM_KEYS = 11;

    localparam logic [3:0] KEY_START    = 4'd10;
    localparam logic [3:0] KEY_MOLE_MIN = 4'd1;
    localparam logic [3:0] KEY_MOLE_MAX = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        WAIT = 2'd2,
        JAM  = 2'd3
    } enc_state_e;

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic popcount_gt1(input logic [15:0] vec);
        return (vec & (vec - 16'd1)) != 16'd0;
    endfunction

    function automatic logic [3:0] onehot_index(input logic [15:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (vec[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_debounce_encoder_if.sv
// Key lines in, encoded press status out; master is the encoder, slave its user.
interface keypad_debounce_encoder_if #(
    parameter int NUM_KEYS = 11
) ();
    logic [NUM_KEYS-1:0] key_button_in;
    logic                button_pressed;
    logic [3:0]          button_value;
    logic                press_pulse;
    logic                jam;

    modport master (
        input  key_button_in,
        output button_pressed,
        output button_value,
        output press_pulse,
        output jam
    );

    modport slave (
        output key_button_in,
        input  button_pressed,
        input  button_value,
        input  press_pulse,
        input  jam
    );
endinterface

// File: rtl/keypad_debounce_encoder_key_debounce_ch.sv
// One debounce channel: a shift history sampled on the shared tick; the level
// only moves once the whole history agrees.
module key_debounce_ch #(
    parameter int STABLE_SAMPLES = 8
) (
    input  logic clk_1mhz,
    input  logic rst_n,
    input  logic sync_bit,
    input  logic tick,
    output logic db
);
    logic [STABLE_SAMPLES-1:0] hist_r;
    logic [STABLE_SAMPLES-1:0] hist_next_s;
    logic                      db_r;

    // History with the current synced sample shifted in
    always_comb begin
        hist_next_s = {hist_r[STABLE_SAMPLES-2:0], sync_bit};
    end

    // Sample on tick; change level only on a unanimous history
    always_ff @(posedge clk_1mhz or negedge rst_n) begin
        if (!rst_n) begin
            hist_r <= {STABLE_SAMPLES{1'b0}};
            db_r   <= 1'b0;
        end else if (tick) begin
            hist_r <= hist_next_s;
            if (&hist_next_s) begin
                db_r <= 1'b1;
            end else if (~|hist_next_s) begin
                db_r <= 1'b0;
            end else begin
                db_r <= db_r;
            end
        end else begin
            hist_r <= hist_r;
            db_r   <= db_r;
        end
    end

    assign db = db_r;
endmodule

// File: rtl/keypad_debounce_encoder.sv
// Keypad front end: synchronise, debounce on a shared tick, then accept a single
// key press (multi-key presses are jammed and never reported).
module keypad_debounce_encoder #(
    parameter int NUM_KEYS       = keypad_debounce_encoder_pkg::NUM_KEYS,
    parameter int TICK_CYCLES    = 1000,
    parameter int STABLE_SAMPLES = 8,
    parameter bit ACTIVE_LOW     = 1'b0
) (
    input  logic                        clk_1mhz,
    input  logic                        rst_n,
    keypad_debounce_encoder_if.master   bus
);
    import keypad_debounce_encoder_pkg::*;

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic [NUM_KEYS-1:0] sync1_r, sync2_r, key_sync_s, db_s;
    logic [15:0]         db_ext_s;
    logic [CNT_W-1:0]    cnt_r;
    logic                tick_s;

    enc_state_e  state_r, state_next_s;
    logic        pressed_r, pressed_next_s;
    logic [3:0]  value_r, value_next_s;
    logic        pulse_r, pulse_next_s;
    logic        jam_r, jam_next_s;

    // Two-flop synchroniser, resetting to the released line level
    always_ff @(posedge clk_1mhz or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= {NUM_KEYS{ACTIVE_LOW}};
            sync2_r <= {NUM_KEYS{ACTIVE_LOW}};
        end else begin
            sync1_r <= bus.key_button_in;
            sync2_r <= sync1_r;
        end
    end

    // Normalise to 1 = pressed
    always_comb begin
        if (ACTIVE_LOW) begin
            key_sync_s = ~sync2_r;
        end else begin
            key_sync_s = sync2_r;
        end
    end

    // Free-running sample tick counter
    always_ff @(posedge clk_1mhz or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (tick_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign tick_s = (cnt_r == CNT_W'(TICK_CYCLES - 1));

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        key_debounce_ch #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_ch (
            .clk_1mhz (clk_1mhz),
            .rst_n    (rst_n),
            .sync_bit (key_sync_s[g]),
            .tick     (tick_s),
            .db       (db_s[g])
        );
    end

    // Widen the debounced vector so helpers and value_r indexing fit 4 bits
    always_comb begin
        db_ext_s               = 16'd0;
        db_ext_s[NUM_KEYS-1:0] = db_s;
    end

    // Encoder next-state and next-output logic
    always_comb begin
        state_next_s   = state_r;
        pressed_next_s = pressed_r;
        value_next_s   = value_r;
        pulse_next_s   = 1'b0;
        jam_next_s     = jam_r;
        case (state_r)
            IDLE: begin
                if (db_ext_s == 16'd0) begin
                    state_next_s = IDLE;
                end else if (popcount_gt1(db_ext_s)) begin
                    jam_next_s   = 1'b1;
                    state_next_s = JAM;
                end else begin
                    value_next_s   = onehot_index(db_ext_s);
                    pressed_next_s = 1'b1;
                    pulse_next_s   = 1'b1;
                    state_next_s   = HELD;
                end
            end
            HELD: begin
                if (!db_ext_s[value_r]) begin
                    pressed_next_s = 1'b0;
                    state_next_s   = WAIT;
                end else begin
                    state_next_s = HELD;
                end
            end
            WAIT: begin
                if (db_ext_s == 16'd0) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT;
                end
            end
            JAM: begin
                if (db_ext_s == 16'd0) begin
                    jam_next_s   = 1'b0;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = JAM;
                end
            end
            default: begin
                state_next_s   = IDLE;
                pressed_next_s = 1'b0;
                jam_next_s     = 1'b0;
            end
        endcase
    end

    // Encoder state and registered outputs
    always_ff @(posedge clk_1mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            pressed_r <= 1'b0;
            value_r   <= 4'd0;
            pulse_r   <= 1'b0;
            jam_r     <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            pressed_r <= pressed_next_s;
            value_r   <= value_next_s;
            pulse_r   <= pulse_next_s;
            jam_r     <= jam_next_s;
        end
    end

    assign bus.button_pressed = pressed_r;
    assign bus.button_value   = value_r;
    assign bus.press_pulse    = pulse_r;
    assign bus.jam            = jam_r;
endmodule
